status_flag_unit: RTL and testbench

- Producer side of the NZCV condition flags consumed by the pipeline's condition-check logic.
- Sits in the EXE stage. Derives N/Z/C/V from the ALU command, its operands and the ALU result, and holds them in the architectural status register.
- Commits flags only for flag-setting instructions whose condition passed and which are not stalled or flushed.
- Provides a same-cycle bypass value, plus a saved-status shadow register for exception entry and return.

---
 rtl/status_flag_unit.sv | 52 +++++
 tb/tb_status_flag_unit.sv | 94 +++++++++
 2 files changed

// File: rtl/status_flag_unit.sv
// status_flag_unit: NZCV flag generation, status register and exception shadow
module status_flag_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       exe_cmd,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             s_bit,
    input  logic             cond_pass,
    input  logic             stall,
    input  logic             flush,
    input  logic             exc_save,
    input  logic             exc_restore,
    output logic [3:0]       status,
    output logic [3:0]       status_fwd,
    output logic [3:0]       saved_status,
    output logic             flag_update
);
    logic [3:0]     status_q, status_d, saved_q, saved_d, flags;
    logic [WIDTH:0] sum;
    logic           is_add, is_sub, c_in, v, update, unused_sum;
    always_comb begin
        is_add   = exe_cmd == 4'b0010 || exe_cmd == 4'b0011;
        is_sub   = exe_cmd == 4'b0100 || exe_cmd == 4'b0101;
        c_in     = exe_cmd[0] ? status_q[1] : is_sub;
        sum      = {1'b0, op_a} + {1'b0, is_sub ? ~op_b : op_b} + {{WIDTH{1'b0}}, c_in};
        v        = (is_sub ? op_a[WIDTH-1] != op_b[WIDTH-1] : op_a[WIDTH-1] == op_b[WIDTH-1])
                   && sum[WIDTH-1] != op_a[WIDTH-1];
        flags    = {alu_result[WIDTH-1], alu_result == '0,
                    (is_add || is_sub) ? {sum[WIDTH], v} : status_q[1:0]};
        update   = s_bit & cond_pass & ~stall & ~flush & ~exc_restore;
        status_d = exc_restore ? saved_q : update ? flags : status_q;
        saved_d  = exc_save ? status_q : saved_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            status_q <= '0;
            saved_q  <= '0;
        end else begin
            status_q <= status_d;
            saved_q  <= saved_d;
        end
    end
    assign unused_sum   = ^sum[WIDTH-2:0];
    assign status       = status_q;
    assign saved_status = saved_q;
    assign status_fwd   = rst ? 4'b0000 : status_d;
    assign flag_update  = update & ~rst;
endmodule

// File: tb/tb_status_flag_unit.sv
// tb_status_flag_unit: directed vectors with a scoreboard queue checked by a monitor
module tb_status_flag_unit;
    localparam logic [3:0] MOV = 4'b0001, ADD = 4'b0010, SUB = 4'b0100, SBC = 4'b0101, AND = 4'b0110;
    typedef struct packed {
        logic       chk_regs;
        logic [3:0] st;
        logic [3:0] sv;
        logic [3:0] fwd;
        logic       fu;
    } exp_t;
    logic        clk = 1'b0, rst = 1'b1;
    logic [3:0]  exe_cmd = '0;
    logic [31:0] op_a = '0, op_b = '0, alu_result = '0;
    logic        s_bit = 1'b0, cond_pass = 1'b0, stall = 1'b0, flush = 1'b0;
    logic        exc_save = 1'b0, exc_restore = 1'b0;
    logic [3:0]  status, status_fwd, saved_status;
    logic        flag_update;
    exp_t        sb[$];
    int          n_cmp = 0, n_bad = 0, cyc = 0;
    status_flag_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .exe_cmd(exe_cmd), .op_a(op_a), .op_b(op_b),
        .alu_result(alu_result), .s_bit(s_bit), .cond_pass(cond_pass), .stall(stall),
        .flush(flush), .exc_save(exc_save), .exc_restore(exc_restore), .status(status),
        .status_fwd(status_fwd), .saved_status(saved_status), .flag_update(flag_update)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, got, exp);
        end
    endtask
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            if (e.chk_regs) begin
                chk("status", status, e.st);
                chk("saved_status", saved_status, e.sv);
            end
            chk("status_fwd", status_fwd, e.fwd);
            chk("flag_update", {3'b000, flag_update}, {3'b000, e.fu});
            cyc++;
        end
    end
    task automatic row(input logic r, input logic [3:0] cmd, input logic [31:0] a, b, res,
                       input logic s, cp, st, fl, sv, rs, chk_regs,
                       input logic [3:0] e_st, e_sv, e_fwd, input logic e_fu);
        @(posedge clk);
        #1;
        rst = r; exe_cmd = cmd; op_a = a; op_b = b; alu_result = res;
        s_bit = s; cond_pass = cp; stall = st; flush = fl; exc_save = sv; exc_restore = rs;
        sb.push_back('{chk_regs, e_st, e_sv, e_fwd, e_fu});
    endtask
    initial begin
        // rst flg  cmd  a             b             result        s cp st fl sv rs ck  status   saved    fwd      fu
        row(1, ADD, 32'h1,        32'h1,        32'h2,        1,1,0,0,0,0, 0, 4'b0000, 4'b0000, 4'b0000, 0);
        row(1, ADD, 32'h1,        32'h1,        32'h2,        1,1,0,0,0,0, 1, 4'b0000, 4'b0000, 4'b0000, 0);
        row(0, ADD, 32'h7FFFFFFF, 32'h1,        32'h80000000, 1,1,0,0,0,0, 1, 4'b0000, 4'b0000, 4'b1001, 1);
        row(0, SUB, 32'h5,        32'h5,        32'h0,        1,1,0,0,0,0, 1, 4'b1001, 4'b0000, 4'b0110, 1);
        row(0, SBC, 32'h0,        32'h0,        32'h0,        1,1,0,0,0,0, 1, 4'b0110, 4'b0000, 4'b0110, 1);
        row(0, ADD, 32'h0,        32'h0,        32'h0,        1,1,0,0,0,0, 1, 4'b0110, 4'b0000, 4'b0100, 1);
        row(0, SBC, 32'h0,        32'h0,        32'hFFFFFFFF, 1,1,0,0,0,0, 1, 4'b0100, 4'b0000, 4'b1000, 1);
        row(0, ADD, 32'h80000000, 32'h80000000, 32'h0,        1,1,0,0,0,0, 1, 4'b1000, 4'b0000, 4'b0111, 1);
        row(0, AND, 32'h80000001, 32'h80000000, 32'h80000000, 1,1,0,0,0,0, 1, 4'b0111, 4'b0000, 4'b1011, 1);
        row(0, MOV, 32'h0,        32'h0,        32'h0,        1,1,0,0,0,0, 1, 4'b1011, 4'b0000, 4'b0111, 1);
        row(0, SUB, 32'h3,        32'h5,        32'hFFFFFFFE, 1,0,0,0,0,0, 1, 4'b0111, 4'b0000, 4'b0111, 0);
        row(0, SUB, 32'h3,        32'h5,        32'hFFFFFFFE, 0,1,0,0,0,0, 1, 4'b0111, 4'b0000, 4'b0111, 0);
        row(0, SUB, 32'h3,        32'h5,        32'hFFFFFFFE, 1,1,0,1,0,0, 1, 4'b0111, 4'b0000, 4'b0111, 0);
        for (int i = 0; i < 3; i++)
            row(0, SUB, 32'h3,    32'h5,        32'hFFFFFFFE, 1,1,1,0,0,0, 1, 4'b0111, 4'b0000, 4'b0111, 0);
        row(0, SUB, 32'h3,        32'h5,        32'hFFFFFFFE, 1,1,0,0,0,0, 1, 4'b0111, 4'b0000, 4'b1000, 1);
        row(0, SUB, 32'h3,        32'h5,        32'hFFFFFFFE, 0,1,0,0,0,0, 1, 4'b1000, 4'b0000, 4'b1000, 0);
        row(0, ADD, 32'h7FFFFFFF, 32'h1,        32'h80000000, 1,1,0,0,0,0, 1, 4'b1000, 4'b0000, 4'b1001, 1);
        row(0, ADD, 32'h0,        32'h0,        32'h0,        1,1,0,0,1,0, 1, 4'b1001, 4'b0000, 4'b0100, 1);
        row(0, ADD, 32'h7FFFFFFF, 32'h1,        32'h80000000, 1,1,0,0,0,1, 1, 4'b0100, 4'b1001, 4'b1001, 0);
        row(0, SUB, 32'h5,        32'h3,        32'h2,        1,1,0,0,0,0, 1, 4'b1001, 4'b1001, 4'b0010, 1);
        row(0, SUB, 32'h5,        32'h3,        32'h2,        0,1,0,0,1,1, 1, 4'b0010, 4'b1001, 4'b1001, 0);
        row(0, SUB, 32'h5,        32'h3,        32'h2,        0,1,0,0,0,0, 1, 4'b1001, 4'b0010, 4'b1001, 0);
        row(1, ADD, 32'h7FFFFFFF, 32'h1,        32'h80000000, 1,1,0,0,1,1, 1, 4'b1001, 4'b0010, 4'b0000, 0);
        row(0, ADD, 32'h0,        32'h0,        32'h0,        0,0,0,0,0,0, 1, 4'b0000, 4'b0000, 4'b0000, 0);
        @(posedge clk);
        #1;
        s_bit = 1'b0; exc_save = 1'b0; exc_restore = 1'b0;
        for (int i = 0; i < 4 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            n_bad++;
            $display("FAIL drain: %0d expected entries never checked, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
